// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and the reset domains it
// controls: software request and domain acknowledges in, per-domain reset
// requests and sequencer status out.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   sw_rst_req;
  logic [NUM_DOMAINS-1:0] dom_ack;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   seq_busy;
  logic                   seq_done;
  logic                   timeout_err;
  logic [2:0]             err_domain;

  // Environment side: issues requests and reports domain status.
  modport master (
    output sw_rst_req,
    output dom_ack,
    input  dom_rst_n,
    input  seq_busy,
    input  seq_done,
    input  timeout_err,
    input  err_domain
  );

  // Sequencer side.
  modport slave (
    input  sw_rst_req,
    input  dom_ack,
    output dom_rst_n,
    output seq_busy,
    output seq_done,
    output timeout_err,
    output err_domain
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-up / soft-reset sequencer. Holds all domains in reset for a minimum
// time, then releases them one at a time in index order, waiting for each
// domain's synchronized acknowledge before releasing the next one. A missing
// acknowledge parks the sequencer in an error state until software asks for
// a new sequence.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 8
) (
  input logic           clk,
  input logic           rst,
  rst_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [2:0]           IDX_LAST  = 3'(NUM_DOMAINS - 1);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   hold_cnt, hold_cnt_nxt;
  logic [CNT_WIDTH-1:0]   to_cnt, to_cnt_nxt;
  logic [2:0]             idx, idx_nxt;
  logic [NUM_DOMAINS-1:0] rel, rel_nxt;
  logic                   busy, busy_nxt;
  logic                   done, done_nxt;
  logic                   terr, terr_nxt;
  logic [2:0]             err_idx, err_idx_nxt;

  // Zero-extended ack vector so any 3-bit index selects a defined bit.
  logic [7:0] ack_ext;
  assign ack_ext = 8'(bus.dom_ack);

  // Next-state and next-output decode; software request overrides every state.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    to_cnt_nxt   = to_cnt;
    idx_nxt      = idx;
    rel_nxt      = rel;
    busy_nxt     = busy;
    done_nxt     = done;
    terr_nxt     = terr;
    err_idx_nxt  = err_idx;

    if (bus.sw_rst_req) begin
      state_nxt    = HOLD;
      hold_cnt_nxt = {CNT_WIDTH{1'b0}};
      to_cnt_nxt   = {CNT_WIDTH{1'b0}};
      idx_nxt      = 3'd0;
      rel_nxt      = {NUM_DOMAINS{1'b0}};
      busy_nxt     = 1'b1;
      done_nxt     = 1'b0;
      terr_nxt     = 1'b0;
      err_idx_nxt  = 3'd0;
    end else begin
      case (state)
        HOLD: begin
          // Stale acks keep us here: a domain still claiming to be out of
          // reset has not yet seen the reset request.
          if ((hold_cnt == HOLD_LAST) && (bus.dom_ack == {NUM_DOMAINS{1'b0}})) begin
            state_nxt  = WAIT_ACK;
            rel_nxt    = NUM_DOMAINS'(1'b1);
            to_cnt_nxt = {CNT_WIDTH{1'b0}};
            idx_nxt    = 3'd0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt_nxt = hold_cnt + CNT_WIDTH'(1);
          end else begin
            hold_cnt_nxt = hold_cnt;
          end
        end

        WAIT_ACK: begin
          // Ack is checked before the timeout so a last-cycle ack still counts.
          if (ack_ext[idx] && (idx != IDX_LAST)) begin
            rel_nxt    = NUM_DOMAINS'({rel, 1'b1});
            idx_nxt    = idx + 3'd1;
            to_cnt_nxt = {CNT_WIDTH{1'b0}};
          end else if (ack_ext[idx]) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state_nxt   = ERROR;
            rel_nxt     = {NUM_DOMAINS{1'b0}};
            busy_nxt    = 1'b0;
            terr_nxt    = 1'b1;
            err_idx_nxt = idx;
          end else begin
            to_cnt_nxt = to_cnt + CNT_WIDTH'(1);
          end
        end

        DONE: begin
          // Any domain dropping its ack has reset itself; restart everything.
          if (bus.dom_ack != {NUM_DOMAINS{1'b1}}) begin
            state_nxt    = HOLD;
            rel_nxt      = {NUM_DOMAINS{1'b0}};
            hold_cnt_nxt = {CNT_WIDTH{1'b0}};
            busy_nxt     = 1'b1;
            done_nxt     = 1'b0;
          end else begin
            state_nxt = DONE;
          end
        end

        ERROR: begin
          state_nxt = ERROR;
        end

        default: begin
          state_nxt    = HOLD;
          hold_cnt_nxt = {CNT_WIDTH{1'b0}};
          rel_nxt      = {NUM_DOMAINS{1'b0}};
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= {CNT_WIDTH{1'b0}};
      to_cnt   <= {CNT_WIDTH{1'b0}};
      idx      <= 3'd0;
      rel      <= {NUM_DOMAINS{1'b0}};
      busy     <= 1'b1;
      done     <= 1'b0;
      terr     <= 1'b0;
      err_idx  <= 3'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      idx      <= idx_nxt;
      rel      <= rel_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      terr     <= terr_nxt;
      err_idx  <= err_idx_nxt;
    end
  end

  assign bus.dom_rst_n   = rel;
  assign bus.seq_busy    = busy;
  assign bus.seq_done    = done;
  assign bus.timeout_err = terr;
  assign bus.err_domain  = err_idx;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: a table of nominal-sequence vectors,
// directed corner-case sequences and randomized domain behaviour, all compared
// against a counting reference model of the sequencing rules.
module tb_rst_seq_ctrl;
  localparam int N = 3;
  localparam int H = 4;
  localparam int T = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rst_seq_ctrl_if #(.NUM_DOMAINS(N)) bus ();

  rst_seq_ctrl #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(H),
    .ACK_TIMEOUT(T),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: how many domains are released / acknowledged, how long
  // the hold and the current wait have lasted, and whether a timeout occurred.
  int m_rel, m_acked, m_hold, m_wait, m_errdom;
  bit m_err;

  function automatic void model_step(input bit r, input bit s, input logic [N-1:0] a);
    if (r || s) begin
      m_rel = 0; m_acked = 0; m_hold = 0; m_wait = 0; m_err = 1'b0;
      if (r) m_errdom = 0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_acked == N) begin
      if (a != {N{1'b1}}) begin
        m_rel = 0; m_acked = 0; m_hold = 0;
      end
    end else if (m_rel == 0) begin
      if (m_hold >= H - 1 && a == '0) begin
        m_rel = 1; m_wait = 0;
      end else if (m_hold < H - 1) begin
        m_hold++;
      end
    end else begin
      if (a[m_rel-1]) begin
        m_acked++;
        if (m_rel < N) begin
          m_rel++; m_wait = 0;
        end
      end else if (m_wait == T - 1) begin
        m_err = 1'b1; m_errdom = m_rel - 1; m_rel = 0; m_acked = 0;
      end else begin
        m_wait++;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_rstn();
    if (m_err) return '0;
    return N'((1 << m_rel) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic tick(input bit r, input bit s, input logic [N-1:0] a);
    rst = r;
    bus.sw_rst_req = s;
    bus.dom_ack = a;
    @(posedge clk);
    model_step(r, s, a);
    #1;
    chk("model_dom_rst_n", int'(bus.dom_rst_n), int'(exp_rstn()));
    chk("model_seq_busy", int'(bus.seq_busy), int'(!m_err && m_acked < N));
    chk("model_seq_done", int'(bus.seq_done), int'(m_acked == N));
    chk("model_timeout_err", int'(bus.timeout_err), int'(m_err));
    if (m_err) chk("model_err_domain", int'(bus.err_domain), m_errdom);
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] rn, input bit b,
                            input bit d, input bit te);
    chk({name, "_dom_rst_n"}, int'(bus.dom_rst_n), int'(rn));
    chk({name, "_busy"}, int'(bus.seq_busy), int'(b));
    chk({name, "_done"}, int'(bus.seq_done), int'(d));
    chk({name, "_terr"}, int'(bus.timeout_err), int'(te));
  endtask

  // Domains acknowledge one cycle after release; bounded wait for completion.
  task automatic run_to_done(input string name);
    for (int i = 0; i < 40; i++) begin
      if (m_acked == N) break;
      tick(1'b0, 1'b0, exp_rstn());
    end
    chk({name, "_reached_done"}, int'(bus.seq_done), 1);
  endtask

  typedef struct {
    bit         rst;
    bit         sw;
    logic [N-1:0] ack;
    logic [N-1:0] rstn;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t tbl[16];

  task automatic run_table();
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rst, tbl[i].sw, tbl[i].ack);
      expect_out($sformatf("tbl%0d", i), tbl[i].rstn, tbl[i].busy, tbl[i].done, 1'b0);
    end
  endtask

  task automatic reset2(input logic [N-1:0] a);
    tick(1'b1, 1'b0, a);
    tick(1'b1, 1'b0, a);
  endtask

  int age[N];
  int dly[N];

  initial begin
    checks = 0; failures = 0;
    m_rel = 0; m_acked = 0; m_hold = 0; m_wait = 0; m_errdom = 0; m_err = 1'b0;
    rst = 1'b1; bus.sw_rst_req = 1'b0; bus.dom_ack = '0;

    // Nominal sequence: acks follow releases so each step is 3 cycles apart.
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 3'b001, 3'b011, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 3'b001, 3'b011, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 3'b001, 3'b011, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 3'b011, 3'b111, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 3'b011, 3'b111, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 3'b011, 3'b111, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1};
    run_table();

    // Domain 1 never acks: timeout exactly 8 cycles after its release.
    reset2(3'b000);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 3'b000);
    tick(1'b0, 1'b0, 3'b001);
    expect_out("to_rel1", 3'b011, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 3'b001);
    expect_out("to_pre", 3'b011, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 3'b001);
    expect_out("to_hit", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("to_err_domain", int'(bus.err_domain), 1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 3'b000);
    expect_out("to_held", 3'b000, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 3'b000);
    expect_out("to_swclr", 3'b000, 1'b1, 1'b0, 1'b0);
    run_to_done("to_restart");

    // Domain 2 drops its ack in DONE: full re-sequence.
    tick(1'b0, 1'b0, 3'b011);
    expect_out("drop", 3'b000, 1'b1, 1'b0, 1'b0);
    run_to_done("drop_restart");

    // Stale ack through reset extends HOLD until it clears.
    reset2(3'b001);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 3'b001);
    expect_out("stale_hold", 3'b000, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 3'b000);
    expect_out("stale_rel", 3'b001, 1'b1, 1'b0, 1'b0);

    // Ack arriving on the last timeout cycle wins.
    reset2(3'b000);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 3'b000);
    tick(1'b0, 1'b0, 3'b001);
    expect_out("ack_wins", 3'b011, 1'b1, 1'b0, 1'b0);

    // Software request on the cycle domain 1 acks: abort, ack ignored.
    tick(1'b0, 1'b1, 3'b011);
    expect_out("sw_abort", 3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 3'b000);
    expect_out("sw_rehold", 3'b000, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 3'b000);
    expect_out("sw_rel0", 3'b001, 1'b1, 1'b0, 1'b0);

    // Reset mid-sequence, then the nominal sequence again.
    tick(1'b0, 1'b0, 3'b001);
    expect_out("mid_pre", 3'b011, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 3'b011);
    expect_out("mid_rst", 3'b000, 1'b1, 1'b0, 1'b0);
    run_table();

    // Randomized domains with random ack latency, glitches and requests.
    for (int k = 0; k < N; k++) begin
      age[k] = 0; dly[k] = 1;
    end
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] a, rn;
      bit r, s;
      rn = exp_rstn();
      for (int k = 0; k < N; k++) begin
        if (rn[k]) begin
          age[k]++;
        end else begin
          age[k] = 0;
          dly[k] = int'($urandom_range(1, 10));
        end
        a[k] = (age[k] >= dly[k]);
      end
      if ($urandom_range(0, 39) == 0) a[$urandom_range(0, N-1)] = 1'b0;
      if ($urandom_range(0, 49) == 0) a[$urandom_range(0, N-1)] = 1'b1;
      s = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 399) == 0);
      tick(r, s, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Power-up/soft-reset sequencer for the multi-clock system; sits in the always-on clock domain ahead of the per-domain reset synchronizers.
- Holds every domain in reset for a minimum time, then releases domains one at a time in fixed index order (0 first).
- Releases the next domain only after the previous domain reports, via synchronized acknowledge, that its synchronized reset has deasserted.
- Flags a per-domain acknowledge timeout and supports software-requested full re-sequencing.

Parameters:
- NUM_DOMAINS, 3, number of sequenced reset domains (1..8).
- HOLD_CYCLES, 16, minimum clk cycles all domains are held in reset (>=1).
- ACK_TIMEOUT, 64, max clk cycles to wait for a domain ack after its release (>=2).
- CNT_WIDTH, 8, width of hold/timeout counters; must hold max(HOLD_CYCLES, ACK_TIMEOUT).

Ports:
- clk  input  1  controller clock (always-on domain).
- rst  input  1  reset; synchronous, active-high, sampled on rising clk.
- sw_rst_req  input  1  single-cycle software request to re-reset all domains.
- dom_ack  input  NUM_DOMAINS  per-domain "out of reset" level, already synchronized into clk; 1 = domain released.
- dom_rst_n  output  NUM_DOMAINS  per-domain reset request to that domain's synchronizer, active-low; registered.
- seq_busy  output  1  high while sequencing (HOLD or WAIT_ACK).
- seq_done  output  1  high while all domains are released and acknowledged.
- timeout_err  output  1  sticky timeout flag.
- err_domain  output  3  index of the domain that timed out; valid while timeout_err=1.

Behaviour:
- All outputs registered. While rst=1:
  - state=HOLD, dom_rst_n=0, seq_busy=1, seq_done=0, timeout_err=0, err_domain=0.
  - Counters=0, domain index idx=0.
- Priority, highest first: rst, then sw_rst_req, then dom_ack / counter events.
- HOLD:
  - dom_rst_n all 0. hold_cnt increments each cycle, saturating at HOLD_CYCLES-1.
  - Exit requires hold_cnt==HOLD_CYCLES-1 AND dom_ack all 0. Stale acks extend HOLD indefinitely; no timeout applies in HOLD.
  - On exit: dom_rst_n[0]<=1, to_cnt<=0, idx<=0, go to WAIT_ACK.
  - With acks low, dom_rst_n[0] rises at the HOLD_CYCLES-th clk edge after the first edge with rst=0.
- WAIT_ACK:
  - to_cnt increments each cycle; dom_ack[idx] is sampled.
  - dom_ack[idx]=1 and idx<NUM_DOMAINS-1: dom_rst_n[idx+1]<=1, idx<=idx+1, to_cnt<=0 on the same edge. No extra gap cycles.
  - dom_ack[idx]=1 and idx==NUM_DOMAINS-1: go to DONE; seq_done<=1, seq_busy<=0.
  - Ack and to_cnt==ACK_TIMEOUT-1 in the same cycle: ack wins.
  - to_cnt==ACK_TIMEOUT-1 without ack: go to ERROR; timeout_err<=1, err_domain<=idx, dom_rst_n<=all 0.
- DONE:
  - dom_rst_n all 1, seq_done=1.
  - Any dom_ack bit dropping to 0 is a spontaneous domain reset. Response: dom_rst_n<=all 0, seq_done<=0, seq_busy<=1, clear hold_cnt, go to HOLD (full re-sequence). timeout_err is unchanged.
- ERROR:
  - dom_rst_n all 0, seq_busy=0, seq_done=0; timeout_err and err_domain hold.
  - Leaves only on sw_rst_req or rst.
- sw_rst_req in any state:
  - On the next edge: dom_rst_n<=all 0, seq_done<=0, seq_busy<=1, counters and idx cleared, timeout_err<=0, go to HOLD.
  - A request arriving mid-WAIT_ACK aborts the sequence and discards any ack seen in that cycle.
- Monotonic release: once set, dom_rst_n bits only clear all together. Bit k+1 never rises before bit k.
- err_domain bits above clog2(NUM_DOMAINS) are driven 0.

Test Plan:
- NUM_DOMAINS=3, HOLD_CYCLES=4, ACK_TIMEOUT=8, acks 0, rst pulsed 1 for 2 cycles, each dom_ack[k] raised 2 cycles after dom_rst_n[k] rises -> dom_rst_n goes 001 at the 4th edge after rst=0, then 011 and 111 at 3-cycle spacing; seq_done=1 one edge after dom_ack=111; seq_busy=0.
- Same config, dom_ack[1] never rises -> 8 cycles after dom_rst_n=011, timeout_err=1, err_domain=1, dom_rst_n=000, state held; sw_rst_req pulse -> timeout_err=0, sequence restarts and completes.
- In DONE, drop dom_ack[2] for 1 cycle -> next edge dom_rst_n=000, seq_done=0, seq_busy=1; full re-sequence follows and ends with seq_done=1.
- dom_ack[0] held 1 (stale) through reset -> HOLD persists beyond 4 cycles with dom_rst_n=000 until dom_ack[0] goes 0; release follows on the next edge.
- sw_rst_req on the same cycle dom_ack[1]=1 arrives in WAIT_ACK (idx=1) -> dom_rst_n=000, idx=0, HOLD entered; ack ignored.
- rst asserted mid-sequence (dom_rst_n=011) -> next edge all outputs at reset values; behaviour after release matches the first scenario.
